// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 VGA timing constants and the raster controller state encoding.
package vga_timing_pkg;

    localparam int H_DISPLAY = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int V_DISPLAY = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int CNT_W     = 10;

    localparam int H_TOTAL      = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_DISPLAY + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_DISPLAY + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_DISPLAY + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_RUN  = 1'b1;

    typedef enum logic {
        IDLE = STATE_IDLE,
        RUN  = STATE_RUN
    } state_e;

endpackage

// File: rtl/sync_axis_cnt.sv
// One raster axis: wrapping position counter with registered sync and visible-area
// decode taken from the next count, so all three outputs change together.
module sync_axis_cnt #(
    parameter int TOTAL   = 800,
    parameter int DISPLAY = 640,
    parameter int FP      = 16,
    parameter int SYNC    = 96,
    parameter int CNT_W   = 10
) (
    input  logic             CLK_NX,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             sync_n,
    output logic             active
);

    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(DISPLAY + FP);
    localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(DISPLAY + FP + SYNC);
    localparam logic [CNT_W-1:0] DISP_END   = CNT_W'(DISPLAY);

    logic [CNT_W-1:0] count_q, count_d;
    logic             sync_n_q, sync_n_d;
    logic             active_q, active_d;

    assign wrap = inc && (count_q == LAST);

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch can be inferred.
        count_d  = count_q;
        sync_n_d = 1'b1;
        active_d = 1'b0;
        if (clr || wrap) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + 1'b1;
        end
        // A cleared axis presents the idle look regardless of what position 0 would decode to.
        if (!clr) begin
            sync_n_d = !((count_d >= SYNC_START) && (count_d < SYNC_END));
            active_d = (count_d < DISP_END);
        end
    end

    always_ff @(posedge CLK_NX) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            count_q  <= '0;
            sync_n_q <= 1'b1;
            active_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            sync_n_q <= sync_n_d;
            active_q <= active_d;
        end
    end

    assign count  = count_q;
    assign sync_n = sync_n_q;
    assign active = active_q;

endmodule

// File: rtl/vga_sync_ctrl.sv
// VGA raster sequencer: turns the divider's pixel-rate signal into counters, syncs and
// blanking, with a run/stop handshake that only starts or stops on frame boundaries.
module vga_sync_ctrl #(
    parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
    parameter int H_FP      = vga_timing_pkg::H_FP,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BP      = vga_timing_pkg::H_BP,
    parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
    parameter int V_FP      = vga_timing_pkg::V_FP,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BP      = vga_timing_pkg::V_BP,
    parameter int CNT_W     = vga_timing_pkg::CNT_W
) (
    input  logic             CLK_NX,
    input  logic             reset,
    input  logic             pixel_rate,
    input  logic             run,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             line_end,
    output logic             frame_start,
    output logic             busy
);

    import vga_timing_pkg::*;

    localparam int               H_TOT      = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int               V_TOT      = V_DISPLAY + V_FP + V_SYNC + V_BP;
    localparam logic [CNT_W-1:0] H_PRE_LAST = CNT_W'(H_TOT - 2);

    state_e           state_q, state_d;
    logic             pixel_rate_q;
    logic             pix_tick;
    logic             stop_pending_q, stop_pending_d;
    logic             line_end_q, line_end_d;
    logic             frame_start_q, frame_start_d;
    logic             h_inc, cnt_clr, frame_end;
    logic [CNT_W-1:0] h_count, v_count;
    logic             h_wrap, v_wrap;
    logic             h_sync_n, v_sync_n;
    logic             h_active, v_active;

    assign pix_tick  = pixel_rate & ~pixel_rate_q;
    assign h_inc     = pix_tick && (state_q == RUN);
    assign frame_end = h_wrap && v_wrap;
    assign cnt_clr   = (state_d == IDLE);

    always_comb begin
        state_d        = state_q;
        stop_pending_d = stop_pending_q;
        frame_start_d  = 1'b0;
        line_end_d     = h_inc && (h_count == H_PRE_LAST);
        case (state_q)
            IDLE: begin
                stop_pending_d = 1'b0;
                if (pix_tick && run) begin
                    state_d       = RUN;
                    frame_start_d = 1'b1;
                end
            end
            RUN: begin
                // run is sampled every cycle; only its value going into the frame end matters.
                stop_pending_d = ~run;
                if (frame_end) begin
                    if (stop_pending_q) begin
                        state_d        = IDLE;
                        stop_pending_d = 1'b0;
                    end else begin
                        frame_start_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_NX) begin
        // Tracks the input even during reset, so a level already high at release is not a tick.
        pixel_rate_q <= pixel_rate;
        if (reset) begin
            state_q        <= IDLE;
            stop_pending_q <= 1'b0;
            line_end_q     <= 1'b0;
            frame_start_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            stop_pending_q <= stop_pending_d;
            line_end_q     <= line_end_d;
            frame_start_q  <= frame_start_d;
        end
    end

    sync_axis_cnt #(
        .TOTAL  (H_TOT),
        .DISPLAY(H_DISPLAY),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .CNT_W  (CNT_W)
    ) u_h_axis (
        .CLK_NX(CLK_NX),
        .reset (reset),
        .inc   (h_inc),
        .clr   (cnt_clr),
        .count (h_count),
        .wrap  (h_wrap),
        .sync_n(h_sync_n),
        .active(h_active)
    );

    sync_axis_cnt #(
        .TOTAL  (V_TOT),
        .DISPLAY(V_DISPLAY),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .CNT_W  (CNT_W)
    ) u_v_axis (
        .CLK_NX(CLK_NX),
        .reset (reset),
        .inc   (h_wrap),
        .clr   (cnt_clr),
        .count (v_count),
        .wrap  (v_wrap),
        .sync_n(v_sync_n),
        .active(v_active)
    );

    assign hsync       = h_sync_n;
    assign vsync       = v_sync_n;
    assign video_on    = h_active & v_active;
    assign pixel_x     = h_count;
    assign pixel_y     = v_count;
    assign line_end    = line_end_q;
    assign frame_start = frame_start_q;
    assign busy        = (state_q == RUN);

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// Bench for vga_sync_ctrl on a shrunken 15x10 raster: reset/start vector table, frame-level
// counts, stop/resume, mid-frame reset, frozen pixel_rate, then random stimulus vs a position model.
module tb_vga_sync_ctrl;

    localparam int HD = 8, HF = 2, HS = 3, HB = 2;
    localparam int VD = 6, VF = 1, VS = 2, VB = 1;
    localparam int CW = 8;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic          clk = 1'b0;
    logic          reset, pixel_rate, run;
    logic          hsync, vsync, video_on, line_end, frame_start, busy;
    logic [CW-1:0] pixel_x, pixel_y;

    always #5 clk = ~clk;

    vga_sync_ctrl #(
        .H_DISPLAY(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_DISPLAY(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CNT_W(CW)
    ) dut (
        .CLK_NX     (clk),
        .reset      (reset),
        .pixel_rate (pixel_rate),
        .run        (run),
        .hsync      (hsync),
        .vsync      (vsync),
        .video_on   (video_on),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .line_end   (line_end),
        .frame_start(frame_start),
        .busy       (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: raster position is a single linear tick index within the frame.
    bit m_running = 0;
    int m_pos     = 0;
    bit m_prq     = 0;
    bit m_run_prev = 0;
    bit m_le      = 0;
    bit m_fs      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Bundle order: {x, y, hsync, vsync, video_on, line_end, frame_start, busy}
    function automatic logic [21:0] pack(input int x, input int y, input bit hs, input bit vs,
                                         input bit von, input bit le, input bit fs, input bit bz);
        return {8'(x), 8'(y), hs, vs, von, le, fs, bz};
    endfunction

    function automatic logic [21:0] dut_bundle();
        return {pixel_x, pixel_y, hsync, vsync, video_on, line_end, frame_start, busy};
    endfunction

    function automatic logic [21:0] model_bundle();
        int x   = m_running ? m_pos % HT : 0;
        int y   = m_running ? m_pos / HT : 0;
        bit hs  = !(m_running && x >= HD + HF && x < HD + HF + HS);
        bit vs  = !(m_running && y >= VD + VF && y < VD + VF + VS);
        bit von = m_running && x < HD && y < VD;
        return pack(x, y, hs, vs, von, m_le, m_fs, m_running);
    endfunction

    task automatic model_step(input bit rst, input bit pr, input bit rn);
        bit tick = pr && !m_prq;
        m_le = 0;
        m_fs = 0;
        if (rst) begin
            m_running = 0;
            m_pos     = 0;
        end else if (!m_running) begin
            if (tick && rn) begin
                m_running = 1;
                m_pos     = 0;
                m_fs      = 1;
            end
        end else if (tick) begin
            if (m_pos == FRAME - 1) begin
                m_pos = 0;
                if (!m_run_prev) m_running = 0;
                else m_fs = 1;
            end else begin
                m_pos++;
            end
            m_le = m_running && (m_pos % HT == HT - 1);
        end
        m_prq      = pr;
        m_run_prev = rn;
    endtask

    task automatic step(input bit rst, input bit pr, input bit rn);
        reset      = rst;
        pixel_rate = pr;
        run        = rn;
        @(posedge clk);
        #1;
        model_step(rst, pr, rn);
        check("model", dut_bundle(), model_bundle());
    endtask

    task automatic div(input bit rn);
        step(1'b0, !pixel_rate, rn);
    endtask

    typedef struct {
        bit rst, pr, rn;
        int x, y;
        bit hs, vs, von, le, fs, bz;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got, seen_last, drop;
        int cyc, hl, vl, vo, le_n, fsn, x0;
        bit rv, rs, prv;

        reset = 1'b1;
        pixel_rate = 1'b0;
        run = 1'b0;

        // Fields: rst, pr, rn, x, y, hsync, vsync, video_on, line_end, frame_start, busy
        vecs[0]  = '{1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
        vecs[1]  = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0};
        vecs[2]  = '{1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0};
        vecs[3]  = '{0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0};
        vecs[4]  = '{0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0};
        vecs[5]  = '{0, 1, 1, 0, 0, 1, 1, 1, 0, 1, 1};
        vecs[6]  = '{0, 0, 1, 0, 0, 1, 1, 1, 0, 0, 1};
        vecs[7]  = '{0, 1, 1, 1, 0, 1, 1, 1, 0, 0, 1};
        vecs[8]  = '{0, 1, 1, 1, 0, 1, 1, 1, 0, 0, 1};
        vecs[9]  = '{0, 0, 1, 1, 0, 1, 1, 1, 0, 0, 1};
        vecs[10] = '{0, 1, 1, 2, 0, 1, 1, 1, 0, 0, 1};

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].rst, vecs[i].pr, vecs[i].rn);
            check($sformatf("vec%0d", i), dut_bundle(),
                  pack(vecs[i].x, vecs[i].y, vecs[i].hs, vecs[i].vs, vecs[i].von,
                       vecs[i].le, vecs[i].fs, vecs[i].bz));
        end

        // One whole frame at /2: period and per-frame sync/blank/line_end totals.
        got = 0;
        for (int i = 0; i < 4 * FRAME && !got; i++) begin
            div(1);
            got = frame_start;
        end
        check("wait_frame_start", got, 1);
        cyc = 1; hl = !hsync; vl = !vsync; vo = video_on; le_n = line_end;
        got = 0;
        for (int i = 0; i < 4 * FRAME && !got; i++) begin
            div(1);
            if (frame_start) begin
                got = 1;
            end else begin
                cyc++;
                hl += !hsync;
                vl += !vsync;
                vo += video_on;
                le_n += line_end;
            end
        end
        check("frame_start_again", got, 1);
        check("frame_cycles", cyc, 2 * FRAME);
        check("hsync_low_cycles", hl, 2 * HS * VT);
        check("vsync_low_cycles", vl, 2 * HT * VS);
        check("video_on_cycles", vo, 2 * HD * VD);
        check("line_end_pulses", le_n, VT);

        // Stop mid-frame: the frame must finish at the last position, then stay idle.
        got = 0;
        for (int i = 0; i < 4 * FRAME && !got; i++) begin
            div(1);
            got = (pixel_y == 3);
        end
        check("reach_line3", got, 1);
        got = 0; seen_last = 0;
        for (int i = 0; i < 4 * FRAME && !got; i++) begin
            div(0);
            if (pixel_x == CW'(HT - 1) && pixel_y == CW'(VT - 1)) seen_last = 1;
            got = !busy;
        end
        check("stop_to_idle", got, 1);
        check("stop_full_frame", seen_last, 1);
        fsn = 0;
        for (int i = 0; i < 100; i++) begin
            div(0);
            fsn += frame_start;
        end
        check("idle_no_frame_start", fsn, 0);

        // Drop run at line 2, restore at line 5: the next frame follows with no gap.
        got = 0;
        for (int i = 0; i < 4 * FRAME && !got; i++) begin
            div(1);
            got = busy && (pixel_y == 2);
        end
        check("restart_line2", got, 1);
        got = 0; drop = 0;
        for (int i = 0; i < 4 * FRAME && !got; i++) begin
            div(0);
            drop |= !busy;
            got = (pixel_y == 5);
        end
        check("reach_line5", got, 1);
        got = 0;
        for (int i = 0; i < 4 * FRAME && !got; i++) begin
            div(1);
            drop |= !busy;
            got = frame_start;
        end
        check("resume_frame_start", got, 1);
        check("resume_no_drop", drop, 0);

        // Reset mid-frame, then restart on the very first tick.
        got = 0;
        for (int i = 0; i < 4 * FRAME && !got; i++) begin
            div(1);
            got = (pixel_x == 5) && (pixel_y == 4);
        end
        check("reach_5_4", got, 1);
        step(1, 0, 1);
        check("mid_reset_values", dut_bundle(), pack(0, 0, 1, 1, 0, 0, 0, 0));
        step(0, 1, 1);
        check("fs_first_tick", frame_start, 1);

        // pixel_rate held high freezes the raster; the next rising edge advances by one.
        got = 0;
        for (int i = 0; i < 4 * FRAME && !got; i++) begin
            div(1);
            got = (pixel_x == 3) && (pixel_y == 1);
        end
        check("reach_3_1", got, 1);
        step(0, 1, 1);
        x0 = m_pos % HT;
        for (int i = 0; i < 49; i++) step(0, 1, 1);
        check("hold_x", pixel_x, x0);
        step(0, 0, 1);
        step(0, 1, 1);
        check("resume_x", pixel_x, x0 + 1);

        // Random pixel_rate shapes, run toggles away from the frame's last line, rare resets.
        rv = 1;
        prv = pixel_rate;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0 && !(m_running && m_pos / HT == VT - 1)) rv = !rv;
            rs = ($urandom_range(0, 1499) == 0);
            case ((i / 500) % 3)
                0:       prv = !prv;
                1:       prv = (i % 3 == 0);
                default: prv = 1'($urandom_range(0, 1));
            endcase
            step(rs, prv, rv);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
